gpio_pad_mux_ctrl: RTL and testbench

Owns the 32 bidirectional GPIO pads between the pad ring and the SoC core. Each pad is shared between the GPIO peripheral (function 0) and an alternate-function source (function 1, e.g. debug/test observe bus).
Reconfiguration of pad ownership runs through a valid/ready config port. A quiesce sequence tristates each changing pad for a programmable settle window before the new owner takes it, so two drivers never glitch onto one pad.
The block sits between croc_soc GPIO signals and the sg13g2_IOPadInOut30mA instances.

---
 rtl/gpio_pad_mux_pkg.sv | 14 +
 rtl/gpio_pad_mux_slice.sv | 24 ++
 rtl/gpio_pad_mux_ctrl.sv | 120 ++++++++++++
 tb/tb_gpio_pad_mux_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_mux_pkg.sv
// rtl/gpio_pad_mux_pkg.sv - shared types and constants for the GPIO pad ownership mux
package gpio_pad_mux_pkg;

  localparam int NUM_PADS_DEFAULT = 32;

  typedef logic [NUM_PADS_DEFAULT-1:0] pad_mask_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_COMMIT  = 2'd2
  } mux_state_e;

endpackage

// File: rtl/gpio_pad_mux_slice.sv
// rtl/gpio_pad_mux_slice.sv - one pad: owner select plus quiesce gate
module gpio_pad_mux_slice
  import gpio_pad_mux_pkg::*;
(
  input  logic sel_i,
  input  logic gate_i,
  input  logic periph_o_i,
  input  logic periph_oe_i,
  input  logic alt_o_i,
  input  logic alt_oe_i,
  input  logic pad_p2c_i,
  output logic pad_c2p_o,
  output logic pad_c2p_en_o,
  output logic periph_in_o,
  output logic alt_in_o
);

  // A gated pad is fully tristated and isolated from both owners.
  assign pad_c2p_o    = gate_i ? 1'b0 : (sel_i ? alt_o_i  : periph_o_i);
  assign pad_c2p_en_o = gate_i ? 1'b0 : (sel_i ? alt_oe_i : periph_oe_i);
  assign periph_in_o  = pad_p2c_i & ~sel_i & ~gate_i;
  assign alt_in_o     = pad_p2c_i &  sel_i & ~gate_i;

endmodule

// File: rtl/gpio_pad_mux_ctrl.sv
// rtl/gpio_pad_mux_ctrl.sv - pad ownership controller with quiesce-before-commit sequencing
module gpio_pad_mux_ctrl
  import gpio_pad_mux_pkg::*;
#(
  parameter int NumPads      = NUM_PADS_DEFAULT,
  parameter int SettleCycles = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [NumPads-1:0] cfg_sel_i,
  output logic [NumPads-1:0] sel_o,
  output logic               busy_o,
  input  logic [NumPads-1:0] periph_o_i,
  input  logic [NumPads-1:0] periph_oe_i,
  output logic [NumPads-1:0] periph_in_o,
  input  logic [NumPads-1:0] alt_o_i,
  input  logic [NumPads-1:0] alt_oe_i,
  output logic [NumPads-1:0] alt_in_o,
  output logic [NumPads-1:0] pad_c2p_o,
  output logic [NumPads-1:0] pad_c2p_en_o,
  input  logic [NumPads-1:0] pad_p2c_i
);

  localparam int CntW = $clog2(SettleCycles + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(SettleCycles - 1);

  if (SettleCycles < 1) begin : g_bad_settle
    $error("gpio_pad_mux_ctrl: SettleCycles must be >= 1");
  end

  mux_state_e         state_q, state_d;
  logic [NumPads-1:0] sel_q, sel_d;
  logic [NumPads-1:0] pending_q, pending_d;
  logic [NumPads-1:0] gate_q, gate_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    pending_d = pending_q;
    gate_d    = gate_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i) begin
          pending_d = cfg_sel_i;
          gate_d    = cfg_sel_i ^ sel_q;
          // An unchanged map is accepted but never gates any pad.
          if (|(cfg_sel_i ^ sel_q)) begin
            state_d = ST_QUIESCE;
            cnt_d   = CntLoad;
          end
        end
      end
      ST_QUIESCE: begin
        if (cnt_q == '0) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ST_COMMIT: begin
        sel_d   = pending_q;
        gate_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gate_d  = '0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      pending_q <= '0;
      gate_q    <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      gate_q    <= gate_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign sel_o       = sel_q;

  for (genvar i = 0; i < NumPads; i++) begin : g_slice
    gpio_pad_mux_slice u_slice (
      .sel_i        (sel_q[i]),
      .gate_i       (gate_q[i]),
      .periph_o_i   (periph_o_i[i]),
      .periph_oe_i  (periph_oe_i[i]),
      .alt_o_i      (alt_o_i[i]),
      .alt_oe_i     (alt_oe_i[i]),
      .pad_p2c_i    (pad_p2c_i[i]),
      .pad_c2p_o    (pad_c2p_o[i]),
      .pad_c2p_en_o (pad_c2p_en_o[i]),
      .periph_in_o  (periph_in_o[i]),
      .alt_in_o     (alt_in_o[i])
    );
  end

endmodule

// File: tb/tb_gpio_pad_mux_ctrl.sv
// tb/tb_gpio_pad_mux_ctrl.sv - self-checking bench for gpio_pad_mux_ctrl
module tb_gpio_pad_mux_ctrl;

  localparam int N = 32;
  localparam int SETTLE = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [N-1:0] cfg_sel = '0;
  logic [N-1:0] sel;
  logic         busy;
  logic [N-1:0] periph_o = '0, periph_oe = '0, periph_in;
  logic [N-1:0] alt_o = '0, alt_oe = '0, alt_in;
  logic [N-1:0] pad_c2p, pad_c2p_en;
  logic [N-1:0] pad_p2c = '0;

  int total = 0;
  int bad = 0;
  logic [N-1:0] m_sel = '0;
  bit hold_p2c = 1'b0;

  gpio_pad_mux_ctrl #(.NumPads(N), .SettleCycles(SETTLE)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_sel_i    (cfg_sel),
    .sel_o        (sel),
    .busy_o       (busy),
    .periph_o_i   (periph_o),
    .periph_oe_i  (periph_oe),
    .periph_in_o  (periph_in),
    .alt_o_i      (alt_o),
    .alt_oe_i     (alt_oe),
    .alt_in_o     (alt_in),
    .pad_c2p_o    (pad_c2p),
    .pad_c2p_en_o (pad_c2p_en),
    .pad_p2c_i    (pad_p2c)
  );

  always #5 clk = ~clk;

  // Reference: each pad is either isolated (changing owner) or wired to exactly one owner.
  function automatic logic [4*N-1:0] model_pads(input logic [N-1:0] s, input logic [N-1:0] g);
    logic [N-1:0] c2p, en, pin, ain;
    for (int i = 0; i < N; i++) begin
      c2p[i] = 1'b0; en[i] = 1'b0; pin[i] = 1'b0; ain[i] = 1'b0;
      if (!g[i]) begin
        if (s[i]) begin
          c2p[i] = alt_o[i]; en[i] = alt_oe[i]; ain[i] = pad_p2c[i];
        end else begin
          c2p[i] = periph_o[i]; en[i] = periph_oe[i]; pin[i] = pad_p2c[i];
        end
      end
    end
    return {c2p, en, pin, ain};
  endfunction

  task automatic rand_io();
    periph_o = $urandom; periph_oe = $urandom;
    alt_o = $urandom; alt_oe = $urandom;
    if (!hold_p2c) pad_p2c = $urandom;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs one config handshake and checks every cycle until the block is idle again.
  task automatic do_reconfig(input logic [N-1:0] nsel, input string tag, input bit inject);
    logic [N-1:0] g;
    g = nsel ^ m_sel;
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_before got=%b exp=1", tag, cfg_ready);
    end
    cfg_sel = nsel; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int k = 0; k <= SETTLE && g != '0; k++) begin
      rand_io();
      if (inject && k >= 1 && k < SETTLE) begin
        cfg_sel = 32'h1; cfg_valid = 1'b1;
      end else begin
        cfg_valid = 1'b0;
      end
      #1;
      total++;
      if ({busy, cfg_ready, sel} !== {1'b1, 1'b0, m_sel}) begin
        bad++; $display("FAIL %s busy_ready_sel k=%0d got=%b%b_%h exp=10_%h", tag, k, busy, cfg_ready, sel, m_sel);
      end
      total++;
      if ({pad_c2p, pad_c2p_en, periph_in, alt_in} !== model_pads(m_sel, g)) begin
        bad++; $display("FAIL %s pads_gated k=%0d got=%h exp=%h", tag, k,
                        {pad_c2p, pad_c2p_en, periph_in, alt_in}, model_pads(m_sel, g));
      end
      tick();
    end
    cfg_valid = 1'b0;
    m_sel = nsel;
    rand_io(); #1;
    total++;
    if ({busy, cfg_ready, sel} !== {1'b0, 1'b1, m_sel}) begin
      bad++; $display("FAIL %s done_state got=%b%b_%h exp=01_%h", tag, busy, cfg_ready, sel, m_sel);
    end
    total++;
    if ({pad_c2p, pad_c2p_en, periph_in, alt_in} !== model_pads(m_sel, '0)) begin
      bad++; $display("FAIL %s pads_after got=%h exp=%h", tag,
                      {pad_c2p, pad_c2p_en, periph_in, alt_in}, model_pads(m_sel, '0));
    end
  endtask

  task automatic test_reset();
    periph_o = 32'hA5A5A5A5; periph_oe = 32'hFFFFFFFF;
    alt_o = $urandom; alt_oe = $urandom; pad_p2c = $urandom;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({pad_c2p, pad_c2p_en} !== {32'hA5A5A5A5, 32'hFFFFFFFF}) begin
      bad++; $display("FAIL reset_pads got=%h_%h exp=a5a5a5a5_ffffffff", pad_c2p, pad_c2p_en);
    end
    total++;
    if ({sel, cfg_ready, busy} !== {32'h0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_ctrl got=%h_%b%b exp=00000000_10", sel, cfg_ready, busy);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    m_sel = '0;
  endtask

  task automatic test_reconfig();
    do_reconfig(32'h8, "reconfig_pad3", 1'b0);
  endtask

  task automatic test_noop();
    do_reconfig(m_sel, "noop", 1'b0);
  endtask

  task automatic test_busy_ignore();
    do_reconfig(32'h40, "busy_first", 1'b1);
    total++;
    if (sel !== 32'h40) begin
      bad++; $display("FAIL busy_inject_ignored got=%h exp=00000040", sel);
    end
    tick();
    do_reconfig(32'h2, "busy_second", 1'b0);
    total++;
    if (sel !== 32'h2) begin
      bad++; $display("FAIL busy_final_sel got=%h exp=00000002", sel);
    end
  endtask

  task automatic test_inputs();
    hold_p2c = 1'b1; pad_p2c = 32'h3;
    do_reconfig(32'h1, "inputs_set", 1'b0);
    total++;
    if ({alt_in, periph_in} !== {32'h1, 32'h2}) begin
      bad++; $display("FAIL inputs_split got=%h_%h exp=00000001_00000002", alt_in, periph_in);
    end
    do_reconfig(32'h3, "inputs_pad1", 1'b0);
    hold_p2c = 1'b0;
  endtask

  task automatic test_reset_mid();
    cfg_sel = m_sel ^ 32'hF0; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    rand_io();
    rst_n = 1'b0;
    #1;
    m_sel = '0;
    total++;
    if ({sel, cfg_ready, busy} !== {32'h0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL midreset_ctrl got=%h_%b%b exp=00000000_10", sel, cfg_ready, busy);
    end
    total++;
    if ({pad_c2p, pad_c2p_en, periph_in, alt_in} !== model_pads('0, '0)) begin
      bad++; $display("FAIL midreset_pads got=%h exp=%h",
                      {pad_c2p, pad_c2p_en, periph_in, alt_in}, model_pads('0, '0));
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_reconfig(32'h00010001, "after_reset", 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] nsel;
    for (int r = 0; r < 8; r++) begin
      nsel = ($urandom_range(0, 3) == 0) ? m_sel : m_sel ^ ($urandom & $urandom);
      do_reconfig(nsel, "random", 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_reconfig();
    test_noop();
    test_busy_ignore();
    test_inputs();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
